// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with a request/response handshake.
// One request at a time: IDLE accepts, BUSY burns WAIT_CYCLES wait states
// and then performs the access, RESP presents a one-cycle response strobe.
// Misaligned, out-of-range and reserved-size requests fault without writing.
module data_memory_ctrl #(
   parameter int BYTE_SIZE   = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [1:0]             req_size,
   input  logic                   req_signed,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [BYTE_SIZE*8-1:0] req_wdata,
   output logic                   resp_valid,
   output logic [BYTE_SIZE*8-1:0] resp_rdata,
   output logic                   resp_fault
);

   localparam int DW = BYTE_SIZE * 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LB = $clog2(BYTE_SIZE);
   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   // Wide enough that addr + size can never wrap before the bound compare.
   localparam int EW = ADDR_WIDTH + 33;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state_q;
   logic [CW-1:0]         cnt_q;
   logic                  we_q;
   logic [1:0]            size_q;
   logic                  signed_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DW-1:0]         wdata_q;
   logic                  req_ready_q;
   logic                  resp_valid_q;
   logic                  resp_fault_q;
   logic [DW-1:0]         resp_rdata_q;
   logic [7:0]            mem_q [DEPTH];

   logic [BYTE_SIZE-1:0]  be_s;
   logic [EW-1:0]         nbytes_s;
   logic [EW-1:0]         end_s;
   logic                  misalign_s;
   logic                  size_bad_s;
   logic [IW-1:0]         idx_s;
   logic [DW-1:0]         raw_s;
   logic [DW-1:0]         ext_s;
   logic                  fault_d;
   logic [DW-1:0]         rdata_d;
   logic                  access_s;

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_fault = resp_fault_q;
   assign resp_rdata = resp_rdata_q;

   assign idx_s    = addr_q[IW-1:0];
   assign access_s = (state_q == BUSY) && (cnt_q == '0);

   // Decode access size into byte lanes, then check alignment and range.
   always_comb begin
      be_s       = '0;
      nbytes_s   = '0;
      misalign_s = 1'b0;
      size_bad_s = 1'b0;
      case (size_q)
         2'b00: begin
            be_s     = BYTE_SIZE'(1'b1);
            nbytes_s = EW'(1);
         end
         2'b01: begin
            be_s       = BYTE_SIZE'(2'b11);
            nbytes_s   = EW'(2);
            misalign_s = addr_q[0];
         end
         2'b10: begin
            be_s       = '1;
            nbytes_s   = EW'(BYTE_SIZE);
            misalign_s = |addr_q[LB-1:0];
         end
         default: begin
            size_bad_s = 1'b1;
         end
      endcase
      end_s   = EW'(addr_q) + nbytes_s;
      fault_d = size_bad_s | misalign_s | (end_s > EW'(DEPTH));
   end

   // Gather the addressed bytes little-endian and apply sign extension.
   always_comb begin
      raw_s = '0;
      ext_s = '0;
      for (int k = 0; k < BYTE_SIZE; k++) begin
         if (be_s[k]) begin
            raw_s[8*k +: 8] = mem_q[idx_s + IW'(k)];
         end else begin
            raw_s[8*k +: 8] = 8'h00;
         end
      end
      case (size_q)
         2'b00: ext_s = (signed_q && raw_s[7])  ? ({DW{1'b1}} << 8)  : '0;
         2'b01: ext_s = (signed_q && raw_s[15]) ? ({DW{1'b1}} << 16) : '0;
         default: ext_s = '0;
      endcase
      if (fault_d || we_q) begin
         rdata_d = '0;
      end else begin
         rdata_d = raw_s | ext_s;
      end
   end

   // Storage write on the access edge; contents survive reset.
   always_ff @(posedge clk) begin
      if (!reset && access_s && we_q && !fault_d) begin
         for (int k = 0; k < BYTE_SIZE; k++) begin
            if (be_s[k]) begin
               mem_q[idx_s + IW'(k)] <= wdata_q[8*k +: 8];
            end
         end
      end
   end

   // Control FSM: accept, wait-state countdown, access, one-cycle response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         size_q       <= 2'b00;
         signed_q     <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready_q) begin
                  we_q        <= req_we;
                  size_q      <= req_size;
                  signed_q    <= req_signed;
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  cnt_q       <= CW'(WAIT_CYCLES);
                  req_ready_q <= 1'b0;
                  state_q     <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  resp_valid_q <= 1'b1;
                  resp_fault_q <= fault_d;
                  resp_rdata_q <= rdata_d;
                  state_q      <= RESP;
               end
            end
            RESP: begin
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
               state_q      <= IDLE;
            end
            default: begin
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
               state_q      <= IDLE;
            end
         endcase
      end
   end

endmodule
